// File: rtl/epmp_bus_pkg.sv
// epmp_bus_pkg: bus FSM/op encodings and default widths shared by both ends of the EPMP data bus
package epmp_bus_pkg;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;
endpackage

// File: rtl/epmp_ram.sv
// epmp_ram: single-port synchronous RAM with registered read, no reset
module epmp_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        if (re) dout <= mem[addr];
    end
endmodule

// File: rtl/epmp_mem_resp.sv
// epmp_mem_resp: EPMP external-bus memory responder with wait states and level RDY handshake
module epmp_mem_resp
    import epmp_bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A,
    inout  wire  [DATA_W-1:0] D,
    input  logic              RD,
    input  logic              WR,
    output logic              RDY,
    output logic              Err,
    output logic [ADDR_W-1:0] Debug_Addr
);
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    state_t            state;
    op_t               op;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] rdata;
    logic              req, abort, go;
    op_t               acc_op;
    logic [ADDR_W-1:0] acc_addr;
    assign req      = RD ^ WR;
    assign abort    = (op == OP_RD) ? !RD : !WR;
    // with zero wait states the access happens on the request edge itself, so use the live bus
    assign go       = (state == IDLE) ? (req && WAIT_STATES == 0) : (state == WAIT && !abort && cnt == CW'(1));
    assign acc_op   = (state == IDLE) ? (WR ? OP_WR : OP_RD) : op;
    assign acc_addr = (state == IDLE) ? A : Debug_Addr;
    assign D        = (state == ACK && op == OP_RD) ? rdata : {DATA_W{1'bz}};
    epmp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk  (clk),
        .we   (go && acc_op == OP_WR && !rst),
        .re   (go && acc_op == OP_RD),
        .addr (acc_addr),
        .din  (D),
        .dout (rdata)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op         <= OP_RD;
            cnt        <= '0;
            Debug_Addr <= '0;
            RDY        <= 1'b0;
            Err        <= 1'b0;
        end else begin
            Err <= 1'b0;
            case (state)
                IDLE: begin
                    Err <= RD && WR;
                    if (req) begin
                        Debug_Addr <= A;
                        op         <= WR ? OP_WR : OP_RD;
                        if (WAIT_STATES == 0) begin
                            state <= ACK;
                            RDY   <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CW'(WAIT_STATES);
                        end
                    end
                end
                WAIT: begin
                    if (abort) state <= IDLE;
                    else if (cnt == CW'(1)) begin
                        state <= ACK;
                        RDY   <= 1'b1;
                    end else cnt <= cnt - 1'b1;
                end
                ACK: begin
                    if (!RD && !WR) begin
                        state <= IDLE;
                        RDY   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_epmp_mem_resp.sv
// tb_epmp_mem_resp: directed checks of the responder with 2 and 0 wait states; floating bus reads as 8'hFF
module tb_epmp_mem_resp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] a = '0, td = '0;
    logic rd = 1'b0, wr = 1'b0, te = 1'b0;
    logic rdy, err;
    logic [7:0] dbg;
    tri1 [7:0] d;
    assign d = te ? td : 8'bz;

    logic [7:0] a_0 = '0, td_0 = '0;
    logic rd_0 = 1'b0, wr_0 = 1'b0, te_0 = 1'b0;
    logic rdy_0, err_0;
    logic [7:0] dbg_0;
    tri1 [7:0] d_0;
    assign d_0 = te_0 ? td_0 : 8'bz;

    epmp_mem_resp #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst), .A(a), .D(d), .RD(rd), .WR(wr),
        .RDY(rdy), .Err(err), .Debug_Addr(dbg)
    );
    epmp_mem_resp #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0)) dut_0 (
        .clk(clk), .rst(rst), .A(a_0), .D(d_0), .RD(rd_0), .WR(wr_0),
        .RDY(rdy_0), .Err(err_0), .Debug_Addr(dbg_0)
    );

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        a = addr; td = data; te = 1'b1; wr = 1'b1;
        tick();
        check("wr_wait_rdy", {7'd0, rdy}, 8'h00);
        tick();
        tick();
        check("wr_ack_rdy", {7'd0, rdy}, 8'h01);
        wr = 1'b0; te = 1'b0;
        tick();
        check("wr_release_rdy", {7'd0, rdy}, 8'h00);
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [7:0] exp);
        a = addr; rd = 1'b1;
        tick();
        tick();
        check("rd_wait_rdy", {7'd0, rdy}, 8'h00);
        check("rd_wait_d", d, 8'hFF);
        tick();
        check("rd_ack_rdy", {7'd0, rdy}, 8'h01);
        check("rd_ack_d", d, exp);
        check("rd_dbg", dbg, addr);
        rd = 1'b0;
        tick();
        check("rd_release_rdy", {7'd0, rdy}, 8'h00);
        check("rd_release_d", d, 8'hFF);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_rdy", {7'd0, rdy}, 8'h00);
        check("rst_err", {7'd0, err}, 8'h00);
        check("rst_dbg", dbg, 8'h00);
        check("rst_d", d, 8'hFF);

        do_write(8'h10, 8'hA5);
        do_read(8'h10, 8'hA5);

        // read aborted after one wait cycle, then write abort to 0x20 holding 0x11
        do_write(8'h20, 8'h11);
        a = 8'h20; rd = 1'b1;
        tick();
        rd = 1'b0;
        tick();
        check("rd_abort_rdy", {7'd0, rdy}, 8'h00);
        tick();
        check("rd_abort_rdy2", {7'd0, rdy}, 8'h00);
        wr = 1'b1; td = 8'h77; te = 1'b1;
        tick();
        wr = 1'b0;
        tick();
        tick();
        check("wr_abort_rdy", {7'd0, rdy}, 8'h00);
        te = 1'b0;
        do_read(8'h20, 8'h11);

        rd = 1'b1; wr = 1'b1;
        tick();
        check("err_pulse", {7'd0, err}, 8'h01);
        check("err_rdy", {7'd0, rdy}, 8'h00);
        check("err_d", d, 8'hFF);
        rd = 1'b0; wr = 1'b0;
        tick();
        check("err_clear", {7'd0, err}, 8'h00);
        check("err_no_access_rdy", {7'd0, rdy}, 8'h00);

        // reset on the access edge of a write: memory keeps 0x11
        a = 8'h20; td = 8'h33; te = 1'b1; wr = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_wait_rdy", {7'd0, rdy}, 8'h00);
        check("rst_wait_dbg", dbg, 8'h00);
        rst = 1'b0; wr = 1'b0; te = 1'b0;
        tick();
        do_read(8'h20, 8'h11);

        a = 8'h10; rd = 1'b1;
        tick();
        tick();
        tick();
        check("ack_before_rst_d", d, 8'hA5);
        rst = 1'b1;
        tick();
        check("rst_ack_rdy", {7'd0, rdy}, 8'h00);
        check("rst_ack_d", d, 8'hFF);
        rst = 1'b0; rd = 1'b0;
        tick();

        // address moves during WAIT and ACK are ignored
        a = 8'h40; td = 8'h5A; te = 1'b1; wr = 1'b1;
        tick();
        a = 8'h41;
        tick();
        check("a_wait_dbg", dbg, 8'h40);
        tick();
        check("a_ack_rdy", {7'd0, rdy}, 8'h01);
        a = 8'h42;
        tick();
        check("a_ack_dbg", dbg, 8'h40);
        check("a_ack_hold_rdy", {7'd0, rdy}, 8'h01);
        wr = 1'b0; te = 1'b0;
        tick();
        do_read(8'h40, 8'h5A);

        // zero wait states: write then read of 0xFF at the 2-cycle minimum period
        a_0 = 8'hFF; td_0 = 8'h3C; te_0 = 1'b1; wr_0 = 1'b1;
        tick();
        check("ws0_wr_rdy", {7'd0, rdy_0}, 8'h01);
        check("ws0_wr_dbg", dbg_0, 8'hFF);
        wr_0 = 1'b0; te_0 = 1'b0;
        tick();
        check("ws0_wr_release", {7'd0, rdy_0}, 8'h00);
        rd_0 = 1'b1;
        tick();
        check("ws0_rd_rdy", {7'd0, rdy_0}, 8'h01);
        check("ws0_rd_d", d_0, 8'h3C);
        rd_0 = 1'b0;
        tick();
        check("ws0_rd_release", {7'd0, rdy_0}, 8'h00);
        check("ws0_rd_release_d", d_0, 8'hFF);
        check("ws0_err", {7'd0, err_0}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
